// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment display scanner with brightness PWM
// and frame-synchronous double-buffered display data.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   rst          asynchronous active-high reset
//   data_in      hex nibble per digit, nibble i = bits [4i+3:4i]
//   dp_in        decimal point request per digit (1 = lit)
//   blank_in     per-digit blank (1 = dark)
//   load         single-cycle strobe, captures data/dp/blank into shadow
//   bright       brightness 0..15, used live every cycle
//   led_en       digit enables, active-low, at most one low
//   led_cx       segments, active-low, bit7..bit1 = a..g, bit0 = dp
//   load_pending shadow holds data not yet shown
//   frame_start  one-cycle pulse when a new scan frame begins
//
// Timing: a digit slot is 16 sub-slots of SUB_DIV cycles each; a digit is lit
// during sub-slots 0..bright. Shadow contents move to the active set only on
// the last cycle of a frame, so a frame never mixes old and new data.
module seg_scan_ctrl #(
    parameter int N_DIGITS = 8,
    parameter int SUB_DIV  = 12500
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] data_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blank_in,
    input  logic                  load,
    input  logic [3:0]            bright,
    output logic [N_DIGITS-1:0]   led_en,
    output logic [7:0]            led_cx,
    output logic                  load_pending,
    output logic                  frame_start
);

    localparam int CNT_W = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
    localparam int POS_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SUB_DIV - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_DIGITS - 1);

    // Segment pattern a..g, active-low.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    logic [CNT_W-1:0]      cnt_p0;
    logic [3:0]            sub_p0;
    logic [POS_W-1:0]      pos_p0;

    logic [4*N_DIGITS-1:0] shadow_data;
    logic [N_DIGITS-1:0]   shadow_dp;
    logic [N_DIGITS-1:0]   shadow_blank;
    logic [4*N_DIGITS-1:0] active_data;
    logic [N_DIGITS-1:0]   active_dp;
    logic [N_DIGITS-1:0]   active_blank;

    logic                  cnt_wrap;
    logic                  slot_wrap;
    logic                  frame_end;

    logic [3:0]            cur_nib;
    logic                  digit_on;
    logic [N_DIGITS-1:0]   en_nxt;
    logic [7:0]            cx_nxt;
    logic [N_DIGITS-1:0]   en_p1;
    logic [7:0]            cx_p1;

    assign cnt_wrap  = (cnt_p0 == CNT_LAST);
    assign slot_wrap = cnt_wrap && (sub_p0 == 4'hF);
    assign frame_end = slot_wrap && (pos_p0 == POS_LAST);

    // ---- stage p0: scan counters ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_p0 <= '0;
            sub_p0 <= '0;
            pos_p0 <= '0;
        end else begin
            cnt_p0 <= cnt_wrap ? '0 : cnt_p0 + CNT_W'(1);
            if (cnt_wrap)
                sub_p0 <= sub_p0 + 4'd1;
            if (slot_wrap)
                pos_p0 <= (pos_p0 == POS_LAST) ? '0 : pos_p0 + POS_W'(1);
        end
    end

    // Shadow/active double buffer. On a frame end the transfer uses the shadow
    // value from before this edge, so a load on that same cycle waits a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_data  <= '0;
            shadow_dp    <= '0;
            shadow_blank <= '1;
            active_data  <= '0;
            active_dp    <= '0;
            active_blank <= '1;
            load_pending <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            if (load) begin
                shadow_data  <= data_in;
                shadow_dp    <= dp_in;
                shadow_blank <= blank_in;
            end
            if (frame_end && load_pending) begin
                active_data  <= shadow_data;
                active_dp    <= shadow_dp;
                active_blank <= shadow_blank;
            end
            if (frame_end)
                load_pending <= load;
            else if (load)
                load_pending <= 1'b1;
            frame_start <= frame_end;
        end
    end

    always_comb begin
        en_nxt   = '1;
        cx_nxt   = 8'hFF;
        cur_nib  = active_data[4*int'(pos_p0) +: 4];
        digit_on = !active_blank[pos_p0] && (sub_p0 <= bright);
        if (digit_on) begin
            en_nxt[pos_p0] = 1'b0;
            cx_nxt         = {seg_decode(cur_nib), ~active_dp[pos_p0]};
        end
    end

    // ---- stage p1: registered display outputs ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_p1 <= '1;
            cx_p1 <= 8'hFF;
        end else begin
            en_p1 <= en_nxt;
            cx_p1 <= cx_nxt;
        end
    end

    assign led_en = en_p1;
    assign led_cx = cx_p1;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl with N_DIGITS=4, SUB_DIV=2 (slot 32, frame 128).
// A cycle-indexed reference model derives the scan position from elapsed
// cycles since reset and tracks shadow/active display contents.
module tb_seg_scan_ctrl;

    localparam int N  = 4;
    localparam int SD = 2;
    localparam int SLOT  = 16 * SD;
    localparam int FRAME = SLOT * N;

    localparam logic [6:0] SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   data_in = '0;
    logic [3:0]    dp_in = '0;
    logic [3:0]    blank_in = '0;
    logic          load = 1'b0;
    logic [3:0]    bright = '0;
    logic [3:0]    led_en;
    logic [7:0]    led_cx;
    logic          load_pending;
    logic          frame_start;

    seg_scan_ctrl #(.N_DIGITS(N), .SUB_DIV(SD)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .dp_in        (dp_in),
        .blank_in     (blank_in),
        .load         (load),
        .bright       (bright),
        .led_en       (led_en),
        .led_cx       (led_cx),
        .load_pending (load_pending),
        .frame_start  (frame_start)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int k        = 0;   // clock edges since reset release

    // Reference model state
    logic [15:0] m_data, m_sh_data;
    logic [3:0]  m_dp, m_sh_dp, m_blank, m_sh_blank;
    logic        m_pend;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    task automatic model_reset();
        m_data = '0; m_dp = '0; m_blank = 4'hF;
        m_sh_data = '0; m_sh_dp = '0; m_sh_blank = 4'hF;
        m_pend = 1'b0;
        k = 0;
    endtask

    // One clock: drive inputs at negedge, predict, clock, compare at negedge.
    task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] dpv,
                        input logic [3:0] bl, input logic [3:0] br);
        int pos, sub;
        logic on, boundary;
        logic [3:0] e_en;
        logic [7:0] e_cx;
        logic [3:0] nib;
        load = ld; data_in = d; dp_in = dpv; blank_in = bl; bright = br;
        pos = (k / SLOT) % N;
        sub = (k / SD) % 16;
        boundary = ((k % FRAME) == FRAME - 1);
        on = !m_blank[pos] && (sub <= int'(br));
        nib = m_data[pos*4 +: 4];
        e_en = 4'hF;
        e_cx = 8'hFF;
        if (on) begin
            e_en[pos] = 1'b0;
            e_cx = {SEG[nib], ~m_dp[pos]};
        end
        if (boundary && m_pend) begin
            m_data = m_sh_data; m_dp = m_sh_dp; m_blank = m_sh_blank;
        end
        if (ld) begin
            m_sh_data = d; m_sh_dp = dpv; m_sh_blank = bl;
            m_pend = 1'b1;
        end else if (boundary) begin
            m_pend = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        chk("led_en", 32'(led_en), 32'(e_en));
        chk("led_cx", 32'(led_cx), 32'(e_cx));
        chk("load_pending", 32'(load_pending), 32'(m_pend));
        chk("frame_start", 32'(frame_start), 32'(boundary));
        load = 1'b0;
        k++;
    endtask

    initial begin
        int kk;
        int cnt;
        logic [15:0] rd;
        logic ld;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_led_en", 32'(led_en), 32'hF);
        chk("rst_led_cx", 32'(led_cx), 32'hFF);
        chk("rst_pending", 32'(load_pending), 32'h0);
        chk("rst_frame_start", 32'(frame_start), 32'h0);
        rst = 1'b0;

        // No load: dark, frame_start every frame
        while (k < 300) step(1'b0, 16'(($urandom)), 4'($urandom), 4'h0, 4'($urandom_range(0, 15)));

        // Load 1A2F with dp on digit1, full brightness
        while (k < 512) begin
            kk = k;
            step(kk == 300, 16'h1A2F, 4'b0010, 4'b0000, 4'd15);
            if (kk == 301) chk("pend_after_load", 32'(load_pending), 32'h1);
            if (kk == 384) begin
                chk("dig0_cx", 32'(led_cx), 32'h71);
                chk("dig0_en", 32'(led_en), 32'hE);
            end
            if (kk == 416) begin
                chk("dig1_cx", 32'(led_cx), 32'b00100100);
                chk("dig1_en", 32'(led_en), 32'hD);
            end
            if (kk == 448) chk("dig2_cx", 32'(led_cx), 32'b00010001);
            if (kk == 480) chk("dig3_cx", 32'(led_cx), 32'b10011111);
        end

        // bright=3: 8 of 32 slot cycles lit; load a blanked digit2 meanwhile
        cnt = 0;
        while (k < 640) begin
            kk = k;
            step(kk == 600, 16'h1A2F, 4'b0010, 4'b0100, 4'd3);
            if (kk < 512 + SLOT && !led_en[0]) cnt++;
        end
        chk("duty_bright3", 32'(cnt), 32'd8);

        // Blanked digit2 never enabled during the next frame
        cnt = 0;
        while (k < 768) begin
            step(1'b0, 16'h0, 4'h0, 4'h0, 4'($urandom_range(0, 15)));
            if (!led_en[2]) cnt++;
        end
        chk("digit2_blanked", 32'(cnt), 32'd0);

        // Last-load-wins and load on the boundary cycle
        while (k < 1152) begin
            kk = k;
            ld = (kk == 780) || (kk == 800) || (kk == 895);
            rd = (kk == 780) ? 16'h1111 : (kk == 800) ? 16'h2222 : 16'h3333;
            step(ld, rd, 4'h0, 4'h0, 4'd15);
            if (kk == 896) begin
                chk("two_load_cx", 32'(led_cx), 32'b00100101);
                chk("boundary_load_pend", 32'(load_pending), 32'h1);
            end
            if (kk == 1024) begin
                chk("third_load_cx", 32'(led_cx), 32'b00001101);
                chk("third_load_pend", 32'(load_pending), 32'h0);
            end
        end

        // Randomized traffic including loads on boundary cycles
        while (k < 1900) begin
            ld = ($urandom_range(0, 39) == 0) ||
                 (((k % FRAME) == FRAME - 1) && ($urandom_range(0, 1) == 0));
            step(ld, 16'($urandom), 4'($urandom),
                 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)));
        end

        // Reset while a load is pending
        while ((k % FRAME) != 10) step(1'b0, 16'h0, 4'h0, 4'h0, 4'd15);
        step(1'b1, 16'h8888, 4'hF, 4'h0, 4'd15);
        repeat (5) step(1'b0, 16'h0, 4'h0, 4'h0, 4'd15);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_en", 32'(led_en), 32'hF);
        chk("async_rst_cx", 32'(led_cx), 32'hFF);
        chk("async_rst_pend", 32'(load_pending), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        while (k < 300) step(1'b0, 16'h0, 4'h0, 4'h0, 4'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout k=%0d", k);
        $fatal(1, "timeout");
    end

endmodule
